fetch_ctrl: RTL and testbench

Instruction fetch sequencer between the program ROM and the decode/execute stage. It generates the 10-bit program counter for the ROM and absorbs the ROM's one-cycle registered read latency. It presents each fetched 16-bit instruction with its PC on a valid/ready handshake. It also handles control-flow redirects (JMP and similar) and halts, so that no stale or duplicated instruction reaches the consumer.

---
 rtl/araucaria_pkg.sv | 21 ++
 rtl/fetch_skid_buf.sv | 97 +++++++++
 rtl/fetch_ctrl.sv | 86 ++++++++
 tb/tb_fetch_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/araucaria_pkg.sv
// Shared constants for the araucaria core: widths, opcodes, reset values.
// Latency: n/a (package only).
// Backpressure: n/a.
package araucaria_pkg;

  localparam int PC_W      = 10;
  localparam int INSTR_W   = 16;
  localparam int OPCODE_W  = 6;
  localparam int OPERAND_W = 10;

  localparam logic [OPCODE_W-1:0] OP_NOP  = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_JMP  = 6'h01;
  localparam logic [OPCODE_W-1:0] OP_JZ   = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_HALT = 6'h3F;

  // Decode treats this word as "do nothing"; it is what instr shows out of reset.
  localparam logic [INSTR_W-1:0] NOP_WORD = {OP_NOP, {OPERAND_W{1'b0}}};

  localparam logic [PC_W-1:0] RESET_PC_DEF = '0;

endpackage

// File: rtl/fetch_skid_buf.sv
// Ordered two-entry output/skid buffer holding fetched instructions with their PC.
// Latency: an enqueued entry is visible on out_* the next cycle when the buffer drains.
// Backpressure: holds out_* stable while !deq_rdy; caller must not enqueue when full (use count).
module fetch_skid_buf #(
  parameter int                PW        = 10,
  parameter int                IW        = 16,
  parameter logic [IW-1:0]     RST_INSTR = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          enq_vld,
  input  logic [IW-1:0] enq_instr,
  input  logic [PW-1:0] enq_pc,
  input  logic          deq_rdy,
  output logic          out_vld,
  output logic [IW-1:0] out_instr,
  output logic [PW-1:0] out_pc,
  output logic [1:0]    count
);

  logic          out_v_q, out_v_d;
  logic [IW-1:0] out_instr_q, out_instr_d;
  logic [PW-1:0] out_pc_q, out_pc_d;
  logic          skid_v_q, skid_v_d;
  logic [IW-1:0] skid_instr_q, skid_instr_d;
  logic [PW-1:0] skid_pc_q, skid_pc_d;
  logic          deq;

  assign deq       = out_v_q & deq_rdy;
  assign out_vld   = out_v_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign count     = {1'b0, out_v_q} + {1'b0, skid_v_q};

  // Next-state: keep order output -> skid -> incoming; flush drops everything after any handshake.
  always_comb begin
    out_v_d      = out_v_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_v_d     = skid_v_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (deq) begin
      if (skid_v_q) begin
        out_v_d     = 1'b1;
        out_instr_d = skid_instr_q;
        out_pc_d    = skid_pc_q;
        skid_v_d    = enq_vld;
        if (enq_vld) begin
          skid_instr_d = enq_instr;
          skid_pc_d    = enq_pc;
        end
      end else begin
        out_v_d = enq_vld;
        if (enq_vld) begin
          out_instr_d = enq_instr;
          out_pc_d    = enq_pc;
        end
      end
    end else if (!out_v_q) begin
      out_v_d = enq_vld;
      if (enq_vld) begin
        out_instr_d = enq_instr;
        out_pc_d    = enq_pc;
      end
    end else if (enq_vld) begin
      skid_v_d     = 1'b1;
      skid_instr_d = enq_instr;
      skid_pc_d    = enq_pc;
    end
    if (flush) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end
  end

  // Buffer registers; reset restores the NOP word and PC 0 on the visible output.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_v_q      <= 1'b0;
      out_instr_q  <= RST_INSTR;
      out_pc_q     <= '0;
      skid_v_q     <= 1'b0;
      skid_instr_q <= RST_INSTR;
      skid_pc_q    <= '0;
    end else begin
      out_v_q      <= out_v_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_v_q     <= skid_v_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: drives ROM address, absorbs 1-cycle ROM latency, handles redirect/halt.
// Latency: issue in cycle N -> instr_valid with that PC in cycle N+2; 1 instr/cycle sustained.
// Backpressure: credit-limited issue (max 2 buffered + in-flight); outputs hold while !instr_ready.
module fetch_ctrl
  import araucaria_pkg::*;
#(
  parameter int                           PC_W     = araucaria_pkg::PC_W,
  parameter int                           INSTR_W  = araucaria_pkg::INSTR_W,
  parameter logic [araucaria_pkg::PC_W-1:0] RESET_PC = araucaria_pkg::RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    rom_pc,
  input  logic [INSTR_W-1:0] rom_instr,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt
);

  logic [PC_W-1:0] fpc_q, fpc_d;
  logic            pend_q, pend_d;
  logic [PC_W-1:0] pend_pc_q, pend_pc_d;
  logic [1:0]      buf_count;
  logic [2:0]      occupancy;
  logic [2:0]      capacity;
  logic            deq;
  logic            issue;

  assign rom_pc    = fpc_q;
  assign deq       = instr_valid & instr_ready;
  // Slots in use vs. slots available this cycle (a consumed output frees one).
  assign occupancy = {1'b0, buf_count} + {2'b00, pend_q};
  assign capacity  = 3'd2 + {2'b00, deq};
  // The redirect cycle never issues: rom_pc still shows the stale pointer.
  assign issue     = !halt && !redirect && (occupancy < capacity);

  // Fetch pointer and in-flight tracking; the in-flight read always retires the next cycle.
  always_comb begin
    fpc_d     = fpc_q;
    pend_d    = issue;
    pend_pc_d = pend_pc_q;
    if (issue) begin
      fpc_d     = fpc_q + PC_W'(1);
      pend_pc_d = fpc_q;
    end
    if (redirect) begin
      fpc_d = redirect_pc;
    end
  end

  // Pointer registers with synchronous reset taking priority over redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q     <= PC_W'(RESET_PC);
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      fpc_q     <= fpc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  fetch_skid_buf #(
    .PW        (PC_W),
    .IW        (INSTR_W),
    .RST_INSTR (INSTR_W'(NOP_WORD))
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .enq_vld   (pend_q),
    .enq_instr (rom_instr),
    .enq_pc    (pend_pc_q),
    .deq_rdy   (instr_ready),
    .out_vld   (instr_valid),
    .out_instr (instr),
    .out_pc    (instr_pc),
    .count     (buf_count)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: 1-cycle ROM model, directed per-cycle stimulus, scoreboard on accepted instructions.
// Latency: n/a.
// Backpressure: instr_ready driven from the stimulus table.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rom_pc;
  logic [15:0] rom_instr = '0;
  logic [15:0] instr;
  logic [9:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [9:0]  redirect_pc;
  logic        halt;

  int checks = 0;
  int errors = 0;
  int accepts = 0;
  int cyc = -2;
  logic [9:0] exp_q[$];

  // Stall-hold tracking (previous cycle showed a valid that was not taken).
  logic        hold_chk = 1'b0;
  logic [9:0]  hold_pc  = '0;
  logic [15:0] hold_ins = '0;

  localparam logic [15:0] NOP_W = 16'h0000;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .rom_pc      (rom_pc),
    .rom_instr   (rom_instr),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt)
  );

  function automatic logic [15:0] rom_word(input logic [9:0] pc);
    rom_word = {pc[5:0] ^ 6'h15, pc};
  endfunction

  // Registered ROM: data for the address sampled at this edge appears next cycle.
  always @(posedge clk) rom_instr <= rom_word(rom_pc);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every accepted instruction must be the next expected PC with its ROM word.
  always @(negedge clk) begin
    if (!reset) begin
      if (hold_chk) begin
        check("hold_valid", {31'b0, instr_valid}, 32'd1);
        check("hold_pc", {22'b0, instr_pc}, {22'b0, hold_pc});
        check("hold_instr", {16'b0, instr}, {16'b0, hold_ins});
      end
      if (instr_valid && instr_ready) begin
        accepts++;
        if (exp_q.size() == 0) begin
          check("unexpected_accept", {22'b0, instr_pc}, 32'hFFFF_FFFF);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          check("sb_pc", {22'b0, instr_pc}, {22'b0, e});
          check("sb_instr", {16'b0, instr}, {16'b0, rom_word(e)});
        end
      end
    end
    hold_chk = !reset && !redirect && instr_valid && !instr_ready;
    hold_pc  = instr_pc;
    hold_ins = instr;
  end

  task automatic push_range(input int first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(10'(first + i));
  endtask

  initial begin
    reset       = 1'b1;
    instr_ready = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    halt        = 1'b0;
    @(posedge clk); #1; cyc++;
    @(negedge clk);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", {16'b0, instr}, {16'b0, NOP_W});
    check("rst_ipc", {22'b0, instr_pc}, 32'd0);
    check("rst_rompc", {22'b0, rom_pc}, 32'd0);
    @(posedge clk); #1; cyc++;

    for (int c = 0; c <= 44; c++) begin
      // Per-cycle stimulus table.
      reset       = (c == 33);
      instr_ready = !((c >= 5 && c <= 8) || (c >= 31 && c <= 33) || c >= 40);
      redirect    = (c == 11) || (c == 15);
      redirect_pc = (c == 11) ? 10'd3 : 10'd1022;
      halt        = (c >= 22 && c <= 26);
      // Expected accepted PCs, pushed as the stimulus that creates them is issued.
      if (c == 0)  push_range(0, 6);
      if (c == 12) push_range(3, 2);
      if (c == 16) begin
        exp_q.push_back(10'd1022);
        exp_q.push_back(10'd1023);
        push_range(0, 6);
      end
      if (c == 34) push_range(0, 4);

      @(negedge clk);
      case (c)
        0:  check("c0_rompc", {22'b0, rom_pc}, 32'd0);
        1:  begin
              check("c1_rompc", {22'b0, rom_pc}, 32'd1);
              check("c1_valid", {31'b0, instr_valid}, 32'd0);
            end
        2:  begin
              check("c2_valid", {31'b0, instr_valid}, 32'd1);
              check("c2_ipc", {22'b0, instr_pc}, 32'd0);
            end
        6:  check("stall_rompc6", {22'b0, rom_pc}, 32'd5);
        8:  begin
              check("stall_rompc8", {22'b0, rom_pc}, 32'd5);
              check("stall_ipc8", {22'b0, instr_pc}, 32'd3);
            end
        11: check("redir_old_rompc", {22'b0, rom_pc}, 32'd7);
        12: begin
              check("redir_bubble12", {31'b0, instr_valid}, 32'd0);
              check("redir_rompc12", {22'b0, rom_pc}, 32'd3);
            end
        13: check("redir_bubble13", {31'b0, instr_valid}, 32'd0);
        14: check("redir_first", {21'b0, instr_valid, instr_pc}, {21'b0, 1'b1, 10'd3});
        16: check("wrap_rompc", {22'b0, rom_pc}, 32'd1022);
        18: check("wrap_first", {21'b0, instr_valid, instr_pc}, {21'b0, 1'b1, 10'd1022});
        20: check("wrap_zero", {21'b0, instr_valid, instr_pc}, {21'b0, 1'b1, 10'd0});
        24: check("halt_drained", {31'b0, instr_valid}, 32'd0);
        26: check("halt_rompc", {22'b0, rom_pc}, 32'd4);
        29: check("halt_resume", {21'b0, instr_valid, instr_pc}, {21'b0, 1'b1, 10'd4});
        32: begin
              check("full_rompc", {22'b0, rom_pc}, 32'd8);
              check("full_ipc", {22'b0, instr_pc}, 32'd6);
            end
        34: begin
              check("rst2_valid", {31'b0, instr_valid}, 32'd0);
              check("rst2_instr", {16'b0, instr}, {16'b0, NOP_W});
              check("rst2_ipc", {22'b0, instr_pc}, 32'd0);
              check("rst2_rompc", {22'b0, rom_pc}, 32'd0);
            end
        36: check("rst2_first", {21'b0, instr_valid, instr_pc}, {21'b0, 1'b1, 10'd0});
        default: ;
      endcase
      @(posedge clk); #1; cyc++;
    end

    @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);
    check("accept_total", accepts, 32'd20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
